// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch sequencer. Reads the current PC, fetches the
//            32-bit instruction at that address over a valid/ready memory
//            port, hands it to decode and writes the next PC (PC+4 or a
//            redirect target) back into the PC register.
// Ports    : clk_i, rst_ni            clock, asynchronous active-low reset
//            pc_i                     current PC from the PC register
//            pc_we_o, pc_next_o       PC register write port
//            imem_req_*               fetch request (valid/ready, address)
//            imem_rsp_*               fetch response (pulse, data, error)
//            inst_valid_o/ready_i     decode handshake
//            inst_o, inst_pc_o,
//            inst_fault_o             delivered instruction, PC and fault
//            redirect_i, redirect_pc_i  redirect from execute
//            fetch_count_o            instructions accepted by decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] pc_i,
    output logic        pc_we_o,
    output logic [63:0] pc_next_o,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc_o,
    output logic [1:0]  inst_fault_o,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_MISALN = 2'b10;

    state_e      state_q, state_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] inst_pc_q, inst_pc_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        misaligned;

    assign misaligned = (pc_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            inst_q     <= '0;
            inst_pc_q  <= RESET_PC;
            fault_q    <= FAULT_NONE;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        inst_d           = inst_q;
        inst_pc_d        = inst_pc_q;
        fault_d          = fault_q;
        count_d          = count_q;
        pc_we_o          = 1'b0;
        pc_next_o        = '0;
        imem_req_valid_o = 1'b0;
        imem_req_addr_o  = '0;
        inst_valid_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                imem_req_addr_o = pc_i;
                if (redirect_i) begin
                    // PC is being rewritten this edge; refetch from the new value
                    state_d = S_REQ;
                end else if (misaligned) begin
                    // Deliver a faulting slot without touching memory
                    inst_d    = '0;
                    inst_pc_d = pc_i;
                    fault_d   = FAULT_MISALN;
                    state_d   = S_OUT;
                end else begin
                    imem_req_valid_o = 1'b1;
                    if (imem_req_ready_i) begin
                        req_addr_d = pc_i;
                        state_d    = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_i) begin
                    // A response arriving in the same cycle is simply dropped;
                    // otherwise it is still in flight and must be drained.
                    state_d = imem_rsp_valid_i ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid_i) begin
                    inst_d    = imem_rsp_data_i;
                    inst_pc_d = req_addr_q;
                    fault_d   = {1'b0, imem_rsp_err_i};
                    state_d   = S_OUT;
                end
            end

            S_OUT: begin
                if (redirect_i) begin
                    state_d = S_REQ;
                end else begin
                    inst_valid_o = 1'b1;
                    if (inst_ready_i) begin
                        pc_we_o   = 1'b1;
                        pc_next_o = inst_pc_q + 64'd4;
                        count_d   = count_q + 32'd1;
                        state_d   = S_REQ;
                    end
                end
            end

            S_DRAIN: begin
                if (imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect owns the PC write port in every state, but never during reset
        if (redirect_i && rst_ni) begin
            pc_we_o   = 1'b1;
            pc_next_o = redirect_pc_i;
        end
    end

    assign inst_o        = inst_q;
    assign inst_pc_o     = inst_pc_q;
    assign inst_fault_o  = fault_q;
    assign fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Models the PC register and an
//            instruction memory (word = ~addr[31:0], error on one address),
//            tracks the architectural PC/instruction count at a high level
//            and compares every cycle, plus directed corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] pc_i;
    logic        pc_we_o;
    logic [63:0] pc_next_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic [1:0]  inst_fault_o;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic [31:0] fetch_count_o;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pc_i             (pc_i),
        .pc_we_o          (pc_we_o),
        .pc_next_o        (pc_next_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_fault_o     (inst_fault_o),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_count_o    (fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    // PC register on the other end of the write port
    logic [63:0] pc_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pc_reg <= RESET_PC;
        else if (pc_we_o) pc_reg <= pc_next_o;
    end
    assign pc_i = pc_reg;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    int          ready_pct = 100;
    int          rsp_lat   = 0;
    bit          rnd_lat   = 0;
    logic [63:0] err_addr  = 64'h1;

    initial begin : mem_model
        bit          hs;
        bit          pending;
        int          cnt;
        logic [63:0] hs_addr, paddr;
        pending = 0; cnt = 0; paddr = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            hs      = rst_ni && imem_req_valid_o && imem_req_ready_i;
            hs_addr = imem_req_addr_o;
            @(posedge clk_i);
            #1;
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
            if (!rst_ni) begin
                pending = 0;
            end else begin
                if (hs) begin
                    chk("one_outstanding", {63'd0, pending}, 64'd0);
                    pending = 1;
                    paddr   = hs_addr;
                    cnt     = rnd_lat ? int'($urandom_range(3)) : rsp_lat;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        imem_rsp_valid_i = 1'b1;
                        imem_rsp_data_i  = ~paddr[31:0];
                        imem_rsp_err_i   = (paddr == err_addr);
                        pending = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
            imem_req_ready_i = ($urandom_range(99) < ready_pct);
        end
    end

    // ---------------- architectural reference + monitor ----------------
    logic [63:0] arch_pc   = RESET_PC;
    logic [31:0] exp_count = '0;
    int          cyc       = 0;
    int          hs_cnt    = 0;
    logic [63:0] hs_addr_q[$];
    int          hs_cyc_q[$];

    initial begin : monitor
        logic [1:0]  efault;
        logic [31:0] einst;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                arch_pc   = RESET_PC;
                exp_count = '0;
            end else begin
                chk("pc_reg", pc_i, arch_pc);
                chk("fetch_count", {32'd0, fetch_count_o}, {32'd0, exp_count});
                if (imem_req_valid_o) begin
                    chk("req_addr", imem_req_addr_o, arch_pc);
                    if (imem_req_ready_i) begin
                        hs_cnt++;
                        hs_addr_q.push_back(imem_req_addr_o);
                        hs_cyc_q.push_back(cyc);
                    end
                end
                if (arch_pc[1:0] != 2'b00)
                    chk("misaligned_no_req", {63'd0, imem_req_valid_o}, 64'd0);
                if (redirect_i) begin
                    chk("redir_we", {63'd0, pc_we_o}, 64'd1);
                    chk("redir_next", pc_next_o, redirect_pc_i);
                    chk("redir_quiet", {62'd0, inst_valid_o, imem_req_valid_o}, 64'd0);
                    arch_pc = redirect_pc_i;
                end else if (inst_valid_o && inst_ready_i) begin
                    efault = (arch_pc[1:0] != 2'b00) ? 2'b10 :
                             (arch_pc == err_addr)   ? 2'b01 : 2'b00;
                    einst  = (efault == 2'b10) ? 32'd0 : ~arch_pc[31:0];
                    chk("inst_pc", inst_pc_o, arch_pc);
                    chk("inst", {32'd0, inst_o}, {32'd0, einst});
                    chk("fault", {62'd0, inst_fault_o}, {62'd0, efault});
                    chk("accept_we", {63'd0, pc_we_o}, 64'd1);
                    chk("accept_next", pc_next_o, arch_pc + 64'd4);
                    arch_pc   = arch_pc + 64'd4;
                    exp_count = exp_count + 32'd1;
                end else begin
                    chk("idle_we", {63'd0, pc_we_o}, 64'd0);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic drive_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_inst_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (inst_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_hs(input string nm, output logic [63:0] addr);
        bit ok = 0;
        addr = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (imem_req_valid_o && imem_req_ready_i) begin
                ok   = 1;
                addr = imem_req_addr_o;
                break;
            end
        end
        if (!ok) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic redirect_to(input logic [63:0] tgt);
        drive_edge();
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        drive_edge();
        redirect_i    = 1'b0;
    endtask

    typedef struct {
        logic [63:0] pc;
        int          lat;
        bit          err;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
        logic [63:0] exp_next;
    } vec_t;

    vec_t tbl[6];

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] hold_inst;
        logic [63:0] hold_pc, a;
        int          n_hs0;
        bit          ok;

        tbl[0] = '{64'h0000_0000_8000_0100, 0, 1'b0, 32'h7FFF_FEFF, 2'b00, 64'h0000_0000_8000_0104};
        tbl[1] = '{64'h0000_0000_8000_0102, 0, 1'b0, 32'h0000_0000, 2'b10, 64'h0000_0000_8000_0106};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b0, 32'h0000_0003, 2'b00, 64'h0000_0000_0000_0000};
        tbl[3] = '{64'h0000_0000_0000_0040, 3, 1'b0, 32'hFFFF_FFBF, 2'b00, 64'h0000_0000_0000_0044};
        tbl[4] = '{64'h1234_5678_9ABC_DEF1, 0, 1'b0, 32'h0000_0000, 2'b10, 64'h1234_5678_9ABC_DEF5};
        tbl[5] = '{64'h0000_0000_8000_0200, 2, 1'b1, 32'h7FFF_FDFF, 2'b01, 64'h0000_0000_8000_0204};

        rst_ni        = 1'b0;
        inst_ready_i  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        err_addr      = 64'h0000_0000_8000_0004;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pc_we", {63'd0, pc_we_o}, 64'd0);
        chk("rst_pc_next", pc_next_o, 64'd0);
        chk("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("rst_req_addr", imem_req_addr_o, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("rst_inst", {32'd0, inst_o}, 64'd0);
        chk("rst_inst_pc", inst_pc_o, RESET_PC);
        chk("rst_fault", {62'd0, inst_fault_o}, 64'd0);
        chk("rst_count", {32'd0, fetch_count_o}, 64'd0);

        // Back-to-back fetch after reset: one request every 3 cycles
        inst_ready_i = 1'b1;
        @(negedge clk_i);
        hs_addr_q.delete();
        hs_cyc_q.delete();
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("startup_count", {32'd0, fetch_count_o}, 64'd3);
        if (hs_addr_q.size() >= 3) begin
            chk("startup_addr0", hs_addr_q[0], 64'h8000_0000);
            chk("startup_addr1", hs_addr_q[1], 64'h8000_0004);
            chk("startup_addr2", hs_addr_q[2], 64'h8000_0008);
            chk("startup_gap01", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 64'd3);
            chk("startup_gap12", 64'(hs_cyc_q[2] - hs_cyc_q[1]), 64'd3);
        end else begin
            chk("startup_hs_count", 64'(hs_addr_q.size()), 64'd3);
        end

        // Decode backpressure for 5 cycles
        drive_edge();
        inst_ready_i = 1'b0;
        wait_inst_valid("bp");
        hold_inst = inst_o;
        hold_pc   = inst_pc_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_inst_stable", {32'd0, inst_o}, {32'd0, hold_inst});
            chk("bp_pc_stable", inst_pc_o, hold_pc);
            chk("bp_no_we", {63'd0, pc_we_o}, 64'd0);
        end
        drive_edge();
        inst_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_we", {63'd0, pc_we_o}, 64'd1);
        chk("bp_release_next", pc_next_o, hold_pc + 64'd4);
        drive_edge();
        inst_ready_i = 1'b0;
        @(negedge clk_i);
        chk("bp_single_pulse", {63'd0, pc_we_o}, 64'd0);

        // Redirect while waiting on a slow response
        rsp_lat      = 4;
        inst_ready_i = 1'b1;
        wait_hs("rw_first", a);
        redirect_to(64'h8000_0100);
        wait_hs("rw_next", a);
        chk("rw_next_addr", a, 64'h8000_0100);
        rsp_lat = 0;

        // Directed redirect table
        for (int t = 0; t < 6; t++) begin
            drive_edge();
            inst_ready_i = 1'b0;
            err_addr     = tbl[t].err ? tbl[t].pc : 64'h1;
            rsp_lat      = tbl[t].lat;
            redirect_to(tbl[t].pc);
            n_hs0 = hs_cnt;
            wait_inst_valid("tbl");
            chk("tbl_inst_pc", inst_pc_o, tbl[t].pc);
            chk("tbl_inst", {32'd0, inst_o}, {32'd0, tbl[t].exp_inst});
            chk("tbl_fault", {62'd0, inst_fault_o}, {62'd0, tbl[t].exp_fault});
            if (tbl[t].exp_fault == 2'b10)
                chk("tbl_no_mem_req", 64'(hs_cnt - n_hs0), 64'd0);
            drive_edge();
            inst_ready_i = 1'b1;
            @(negedge clk_i);
            chk("tbl_accept_we", {63'd0, pc_we_o}, 64'd1);
            chk("tbl_next", pc_next_o, tbl[t].exp_next);
            drive_edge();
            inst_ready_i = 1'b0;
        end
        rsp_lat = 0;

        // Reset asserted during WAIT
        redirect_to(64'h8000_0300);
        inst_ready_i = 1'b1;
        rsp_lat      = 2;
        wait_hs("rst_wait", a);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_pc_we", {63'd0, pc_we_o}, 64'd0);
        chk("arst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("arst_req_addr", imem_req_addr_o, 64'd0);
        chk("arst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("arst_inst", {32'd0, inst_o}, 64'd0);
        chk("arst_inst_pc", inst_pc_o, RESET_PC);
        chk("arst_fault", {62'd0, inst_fault_o}, 64'd0);
        chk("arst_count", {32'd0, fetch_count_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        rsp_lat = 0;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;

        // Instruction counter wrap
        drive_edge();
        inst_ready_i = 1'b0;
        @(posedge clk_i);
        #2;
        force dut.count_q = 32'hFFFF_FFFE;
        exp_count = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        drive_edge();
        inst_ready_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (exp_count == 32'd0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk_i);
        chk("count_wrap", {32'd0, fetch_count_o}, 64'd0);
        if (!ok) chk("count_wrap_timeout", 64'd0, 64'd1);

        // Randomized traffic against the reference model
        err_addr  = 64'h8000_0200;
        ready_pct = 70;
        rnd_lat   = 1;
        for (int i = 0; i < 800; i++) begin
            drive_edge();
            inst_ready_i = ($urandom_range(3) != 0);
            redirect_i   = ($urandom_range(19) == 0);
            case ($urandom_range(4))
                0: redirect_pc_i = 64'h8000_0200;
                1: redirect_pc_i = 64'h8000_0000 | 64'({$urandom_range(255), 2'b00});
                2: redirect_pc_i = 64'h8000_0000 | 64'($urandom_range(1023));
                3: redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF8;
                default: redirect_pc_i = {$urandom, $urandom & 32'hFFFF_FFFC};
            endcase
        end
        drive_edge();
        redirect_i   = 1'b0;
        inst_ready_i = 1'b1;
        repeat (20) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
